// File: rtl/gate_memory_sequencer_pkg.sv
// Shared definitions for the gate memory sequencer: default sizes and FSM state encoding.
package gate_memory_sequencer_pkg;

    localparam int DEF_DATA_SIZE   = 14;
    localparam int DEF_ADDR_SIZE   = 19;
    localparam int DEF_MEMORY_SIZE = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        PLAYBACK = 2'd2,
        DRAIN    = 2'd3
    } gate_state_e;

endpackage

// File: rtl/gate_memory_sequencer_if.sv
// Gate memory port: the sequencer is the only master; the memory is the slave.
interface gate_memory_sequencer_if #(
    parameter int DATA_SIZE = 14,
    parameter int ADDR_SIZE = 19
);
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_read;
    logic                 mem_write;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/gate_skid_buffer.sv
// Two-entry FIFO that holds playback words returned by the memory while downstream stalls.
module gate_skid_buffer
    import gate_memory_sequencer_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_push,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_pop,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    output logic [1:0]           o_occupancy
);
    logic [DATA_SIZE-1:0] entry [2];
    logic                 wr_sel;
    logic                 rd_sel;
    logic [1:0]           occ;
    logic                 pop_ok;

    assign pop_ok = i_pop && (occ != 2'd0);

    // NOTE: the storage is reset as well, because o_data has to read zero out of reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            occ      <= 2'd0;
        end else begin
            if (i_push) begin
                entry[wr_sel] <= i_data;
                wr_sel        <= ~wr_sel;
            end
            if (pop_ok) begin
                rd_sel <= ~rd_sel;
            end
            occ <= occ + 2'(i_push) - 2'(pop_ok);
        end
    end

    assign o_data      = entry[rd_sel];
    assign o_valid     = (occ != 2'd0);
    assign o_occupancy = occ;
endmodule

// File: rtl/gate_memory_sequencer.sv
// Gate memory sequencer: captures a gated sample burst into the gate memory and replays
// it as a valid/ready stream. It owns the memory port, so read and write never overlap.
module gate_memory_sequencer
    import gate_memory_sequencer_pkg::*;
#(
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start_capture,
    input  logic                    i_start_playback,
    input  logic [ADDR_SIZE-1:0]    i_length,
    input  logic [DATA_SIZE-1:0]    i_data,
    input  logic                    i_valid,
    output logic [DATA_SIZE-1:0]    o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    gate_memory_sequencer_if.master mem,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [ADDR_SIZE-1:0]    o_count
);
    localparam logic [ADDR_SIZE-1:0] MEM_WORDS = ADDR_SIZE'(MEMORY_SIZE);
    localparam logic [ADDR_SIZE-1:0] ONE       = ADDR_SIZE'(1);

    gate_state_e          state, state_next;
    logic [ADDR_SIZE-1:0] ptr, len, count;
    logic [ADDR_SIZE-1:0] start_len, pb_len;
    logic [ADDR_SIZE-1:0] mem_addr_q;
    logic [DATA_SIZE-1:0] mem_wdata_q;
    logic                 mem_read_q, mem_write_q;
    logic                 cap_accept, pb_accept, wr_fire, last_wr;
    logic                 slots_ok, rd_issue, last_rd, pop, final_pop;
    logic                 skid_valid;
    logic [1:0]           skid_occ;

    assign start_len  = (i_length < MEM_WORDS) ? i_length : MEM_WORDS;
    assign pb_len     = (start_len < count) ? start_len : count;
    assign cap_accept = (state == IDLE) && i_start_capture && (i_length != '0);
    assign pb_accept  = (state == IDLE) && !i_start_capture && i_start_playback
                        && (i_length != '0) && (count != '0);

    assign wr_fire = (state == CAPTURE) && i_valid;
    assign last_wr = wr_fire && (ptr == len - ONE);

    // The slot freed by this cycle's handshake counts as free, which sustains one word per cycle.
    assign pop      = skid_valid && i_ready;
    assign slots_ok = (3'(skid_occ) + 3'(mem_read_q)) < (3'd2 + 3'(pop));
    assign rd_issue = pb_accept || ((state == PLAYBACK) && (ptr < len) && slots_ok);
    assign last_rd  = (state == PLAYBACK) && rd_issue && (ptr == len - ONE);
    assign final_pop = (state == DRAIN) && pop && (skid_occ == 2'd1) && !mem_read_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: state_next gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cap_accept)     state_next = CAPTURE;
                else if (pb_accept) state_next = (pb_len == ONE) ? DRAIN : PLAYBACK;
            end
            CAPTURE:  if (last_wr)   state_next = IDLE;
            PLAYBACK: if (last_rd)   state_next = DRAIN;
            DRAIN:    if (final_pop) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
        o_done = last_wr || final_pop;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ptr         <= '0;
            len         <= '0;
            count       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            mem_write_q <= wr_fire;
            mem_read_q  <= rd_issue;

            if (cap_accept) begin
                ptr <= '0;
                len <= start_len;
            end else if (pb_accept) begin
                // Address 0 is issued right away; the pointer already names the next word.
                ptr <= (pb_len == ONE) ? '0 : ONE;
                len <= pb_len;
            end else if ((wr_fire && !last_wr) || ((state == PLAYBACK) && rd_issue && !last_rd)) begin
                ptr <= ptr + ONE;
            end

            if (wr_fire) begin
                mem_addr_q  <= ptr;
                mem_wdata_q <= i_data;
            end else if (rd_issue) begin
                mem_addr_q  <= pb_accept ? '0 : ptr;
            end

            if (last_wr) count <= len;
        end
    end

    gate_skid_buffer #(.DATA_SIZE(DATA_SIZE)) u_skid (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (mem_read_q),
        .i_data      (mem.mem_rdata),
        .i_pop       (pop),
        .o_data      (o_data),
        .o_valid     (skid_valid),
        .o_occupancy (skid_occ)
    );

    assign o_valid       = skid_valid;
    assign o_count       = count;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_read  = mem_read_q;
    assign mem.mem_write = mem_write_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_gate_memory_sequencer.sv
// Scoreboard bench for gate_memory_sequencer: reference model of the captured burst,
// expected write/read queues, and a monitor that checks memory port and playback stream.
module tb_gate_memory_sequencer;
    localparam int DATA_SIZE   = 14;
    localparam int ADDR_SIZE   = 19;
    localparam int MEMORY_SIZE = 10;

    typedef struct {
        logic [ADDR_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0] data;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_capture = 1'b0;
    logic                 start_playback = 1'b0;
    logic [ADDR_SIZE-1:0] length = '0;
    logic [DATA_SIZE-1:0] data = '0;
    logic                 valid = 1'b0;
    logic [DATA_SIZE-1:0] o_data;
    logic                 o_valid;
    logic                 ready = 1'b1;
    logic                 busy;
    logic                 done;
    logic [ADDR_SIZE-1:0] o_count;

    gate_memory_sequencer_if #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) mem_if ();

    gate_memory_sequencer #(
        .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .MEMORY_SIZE(MEMORY_SIZE)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_start_capture  (start_capture),
        .i_start_playback (start_playback),
        .i_length         (length),
        .i_data           (data),
        .i_valid          (valid),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .i_ready          (ready),
        .mem              (mem_if),
        .o_busy           (busy),
        .o_done           (done),
        .o_count          (o_count)
    );

    always #5 clk = ~clk;

    // Memory: commits writes and registers read data on the falling edge.
    logic [DATA_SIZE-1:0] mem_array [16];
    always @(negedge clk) begin
        if (mem_if.mem_write) mem_array[mem_if.mem_addr[3:0]] <= mem_if.mem_wdata;
        if (mem_if.mem_read)  mem_if.mem_rdata <= mem_array[mem_if.mem_addr[3:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: contents of the last capture and its length.
    logic [DATA_SIZE-1:0] model_mem [MEMORY_SIZE];
    int                   model_count = 0;
    wr_t                  wr_q [$];
    logic [DATA_SIZE-1:0] rd_q [$];
    int                   done_seen = 0;
    int                   hs_count  = 0;

    // Monitor
    bit                   prev_stall = 1'b0;
    logic [DATA_SIZE-1:0] prev_data;
    wr_t                  we;
    logic [DATA_SIZE-1:0] re;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_if.mem_read || mem_if.mem_write)
                check("rw_exclusive", {31'b0, mem_if.mem_read & mem_if.mem_write}, 0);
            if (mem_if.mem_write) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", mem_if.mem_addr, we.addr);
                    check("wr_data", mem_if.mem_wdata, we.data);
                end
            end
            if (prev_stall) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, prev_data);
            end
            if (o_valid && ready) begin
                hs_count++;
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    re = rd_q.pop_front();
                    check("rd_data", o_data, re);
                end
            end
            if (done) done_seen++;
            prev_stall = o_valid && !ready;
            prev_data  = o_data;
        end
    end

    // Downstream ready: 0 = always, 1 = 1,0,0 repeating, 2 = random.
    int ready_mode = 0;
    int phase = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       ready = (phase % 3 == 0);
                2:       ready = 1'($urandom_range(0, 1));
                default: ready = 1'b1;
            endcase
            phase++;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_o_valid"}, o_valid, 0);
        check({tag, "_o_data"}, o_data, 0);
        check({tag, "_mem_read"}, mem_if.mem_read, 0);
        check({tag, "_mem_write"}, mem_if.mem_write, 0);
        check({tag, "_mem_addr"}, mem_if.mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_if.mem_wdata, 0);
        check({tag, "_o_busy"}, busy, 0);
        check({tag, "_o_done"}, done, 0);
        check({tag, "_o_count"}, o_count, 0);
    endtask

    task automatic do_capture(input int n, input bit dense, input bit seq_data, input bit both_starts);
        int l, acc, cyc, d0;
        bit v;
        logic [DATA_SIZE-1:0] d;
        l  = (n < MEMORY_SIZE) ? n : MEMORY_SIZE;
        d0 = done_seen;
        @(posedge clk); #1;
        start_capture  = 1'b1;
        start_playback = both_starts;
        length         = ADDR_SIZE'(n);
        valid          = 1'($urandom_range(0, 1));   // still IDLE: must be dropped
        data           = DATA_SIZE'($urandom);
        @(posedge clk); #1;
        start_capture  = 1'b0;
        start_playback = 1'b0;
        if (l == 0) begin
            valid = 1'b1;
            data  = DATA_SIZE'($urandom);
            @(negedge clk);
            check("len0_ignored_busy", busy, 0);
            @(posedge clk); #1;
            valid = 1'b0;
        end else begin
            acc = 0;
            cyc = 0;
            while (acc < l && cyc < 200) begin
                v = dense || ($urandom_range(0, 3) != 0);
                d = seq_data ? DATA_SIZE'(acc + 1) : DATA_SIZE'($urandom);
                valid = v;
                data  = d;
                start_playback = 1'b0;
                if (!dense) begin
                    start_playback = ($urandom_range(0, 5) == 0);
                    length         = ADDR_SIZE'($urandom_range(1, 15));
                end
                if (v) begin
                    wr_q.push_back('{ADDR_SIZE'(acc), d});
                    model_mem[acc] = d;
                    acc++;
                end
                @(negedge clk);
                check("cap_busy", busy, 1);
                check("cap_done", done, (acc == l));
                @(posedge clk); #1;
                cyc++;
            end
            check("cap_budget", acc, l);
            start_playback = 1'b0;
            valid = 1'b1;
            data  = DATA_SIZE'($urandom);
            @(negedge clk);
            check("cap_busy_fall", busy, 0);
            check("cap_done_single", done, 0);
            @(posedge clk); #1;
            valid = 1'b0;
            model_count = l;
        end
        repeat (2) @(posedge clk);
        #1;
        check("o_count", o_count, model_count);
        check("cap_writes_drained", wr_q.size(), 0);
        check("cap_done_pulses", done_seen - d0, (l > 0));
    endtask

    task automatic do_playback(input int n, input int mode, input bit stray);
        int pl, lat, cyc, d0;
        bit got;
        pl = (n < MEMORY_SIZE) ? n : MEMORY_SIZE;
        if (model_count < pl) pl = model_count;
        d0 = done_seen;
        for (int i = 0; i < pl; i++) rd_q.push_back(model_mem[i]);
        ready_mode = mode;
        @(posedge clk); #1;
        start_playback = 1'b1;
        length         = ADDR_SIZE'(n);
        @(posedge clk); #1;
        start_playback = 1'b0;
        if (pl == 0) begin
            repeat (4) begin
                @(negedge clk);
                check("pb_ignored_busy", busy, 0);
            end
        end else begin
            if (mode == 0) begin
                lat = 1;
                @(negedge clk);
                while (!o_valid && lat < 10) begin
                    @(negedge clk);
                    lat++;
                end
                check("first_valid_latency", lat, 2);
                for (int i = 1; i < pl; i++) begin
                    @(negedge clk);
                    check("throughput_valid", o_valid, 1);
                end
                check("done_with_last", done, 1);
                @(posedge clk); #1;
            end else begin
                cyc = 0;
                got = 1'b0;
                while (!got && cyc < 400) begin
                    if (stray) begin
                        start_capture = ($urandom_range(0, 5) == 0);
                        length        = ADDR_SIZE'($urandom_range(1, 15));
                    end
                    @(negedge clk);
                    got = done;
                    cyc++;
                    @(posedge clk); #1;
                    start_capture = 1'b0;
                end
                check("pb_done_seen", got, 1);
            end
            @(negedge clk);
            check("pb_busy_fall", busy, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("pb_words_drained", rd_q.size(), 0);
        check("pb_done_pulses", done_seen - d0, (pl > 0));
        ready_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, cyc;
        #23;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_capture(5, 1'b1, 1'b1, 1'b0);   // 0x0001..0x0005 at addresses 0..4
        do_playback(5, 0, 1'b0);
        do_playback(9, 1, 1'b0);           // toggled ready, clamped to captured 5
        do_capture(15, 1'b1, 1'b0, 1'b0);  // clamps to MEMORY_SIZE
        do_playback(15, 2, 1'b1);
        do_capture(3, 1'b0, 1'b0, 1'b1);   // simultaneous starts: capture wins
        do_playback(8, 1, 1'b1);           // only 3 words exist
        do_capture(0, 1'b1, 1'b0, 1'b0);   // ignored, o_count keeps 3
        do_playback(0, 0, 1'b0);           // ignored
        do_playback(1, 0, 1'b0);

        for (int it = 0; it < 14; it++) begin
            int m;
            m = $urandom_range(0, 2);
            do_capture($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            do_playback($urandom_range(0, 15), m, (m != 0));
        end

        // Reset in the middle of a playback, after two words have been delivered.
        do_capture(6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) rd_q.push_back(model_mem[i]);
        ready_mode = 0;
        h0 = hs_count;
        @(posedge clk); #1;
        start_playback = 1'b1;
        length         = ADDR_SIZE'(6);
        @(posedge clk); #1;
        start_playback = 1'b0;
        cyc = 0;
        while (hs_count < h0 + 2 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        check("reset_test_two_words", hs_count - h0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        rd_q.delete();
        wr_q.delete();
        model_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_playback(5, 0, 1'b0);           // o_count is 0, so this start is ignored
        check("post_reset_o_count", o_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
